// File: rtl/cozim_pkg.sv
// Shared types for the cycle-driven NoC simulator slice: simulator phase
// encoding, the default packet layout and the injector LFSR step.
package cozim_pkg;

  // Simulator phase, encoded exactly as the 2-bit state seen by the core
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } sim_state_t;

  // Packet layout for the default injector configuration
  typedef struct packed {
    logic [3:0] dest;
    logic [4:0] timestamp;
    logic [7:0] id;
  } packet_t;

  // Right-shifting Galois taps for x^16 + x^14 + x^13 + x^11 + 1
  localparam logic [15:0] LFSR_POLY = 16'hB400;

  function automatic logic [15:0] lfsr_next(input logic [15:0] value);
    logic [15:0] shifted;
    shifted = {1'b0, value[15:1]};
    return value[0] ? (shifted ^ LFSR_POLY) : shifted;
  endfunction

endpackage

// File: rtl/traffic_injector_sync_fifo.sv
// sync_fifo: small synchronous packet buffer with a show-ahead head.
// A push into a full buffer is accepted when a pop happens in the same cycle.
module sync_fifo
  import cozim_pkg::*;
#(
  parameter int  DEPTH = 4,
  parameter type T     = packet_t
) (
  input  logic clk,
  input  logic reset_n,
  input  logic push,
  input  logic pop,
  input  T     wr_data,
  output T     rd_data,
  output logic full,
  output logic empty
);

  localparam int AW = $clog2(DEPTH);

  T               mem [DEPTH];
  logic [AW:0]    wr_ptr_reg;
  logic [AW:0]    rd_ptr_reg;
  logic           do_push;
  logic           do_pop;

  // Extra pointer bit distinguishes full from empty when indices match
  assign empty   = (wr_ptr_reg == rd_ptr_reg);
  assign full    = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                   (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rd_data = mem[rd_ptr_reg[AW-1:0]];

  // Pointer update; reset empties the buffer without touching storage
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
    end
  end

  // Storage write; when full, the slot being written is the one popped this cycle
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_reg[AW-1:0]] <= wr_data;
  end

endmodule

// File: rtl/traffic_injector.sv
// traffic_injector: LFSR-driven synthetic NoC packet source with a
// valid/ready output buffer and IDLE/RUN/DRAIN/DONE phases.
// Build option TRAFFIC_INJECTOR_STALL_EN: an injection that finds the buffer
// full (and no pop) freezes the LFSR and retries next cycle instead of being
// dropped; dropped_count is then constant zero.
module traffic_injector
  import cozim_pkg::*;
#(
  parameter int          MAX_CYCLE_WIDTH = 5,
  parameter int          NODE_ID_WIDTH   = 4,
  parameter int          SRC_ID          = 0,
  parameter int          FIFO_DEPTH      = 4,
  parameter int          RATE_WIDTH      = 8,
  parameter logic [15:0] LFSR_SEED       = 16'hACE1
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       start,
  input  logic [MAX_CYCLE_WIDTH-1:0] current_cycle,
  input  logic [MAX_CYCLE_WIDTH-1:0] stop_cycle,
  input  logic [RATE_WIDTH-1:0]      injection_rate,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [NODE_ID_WIDTH-1:0]   out_dest,
  output logic [MAX_CYCLE_WIDTH-1:0] out_timestamp,
  output logic [7:0]                 out_packet_id,
  output logic [1:0]                 state,
  output logic [15:0]                injected_count,
  output logic [15:0]                dropped_count
);

  typedef struct packed {
    logic [NODE_ID_WIDTH-1:0]   dest;
    logic [MAX_CYCLE_WIDTH-1:0] timestamp;
    logic [7:0]                 id;
  } inj_packet_t;

  localparam logic [NODE_ID_WIDTH-1:0] SRC_NODE = NODE_ID_WIDTH'(SRC_ID);
  // Truncation makes SRC_ID+1 wrap modulo the node count
  localparam logic [NODE_ID_WIDTH-1:0] ALT_NODE = NODE_ID_WIDTH'(SRC_ID + 1);

  sim_state_t               state_reg;
  sim_state_t               state_next;
  logic [15:0]              lfsr_reg;
  logic [7:0]               id_reg;
  logic [15:0]              inj_cnt_reg;

  logic                     in_run;
  logic                     stop_hit;
  logic                     inject;
  logic                     pop;
  logic                     push_ok;
  logic                     blocked;
  logic                     lfsr_adv;
  logic [NODE_ID_WIDTH-1:0] dest_raw;
  logic [NODE_ID_WIDTH-1:0] dest_sel;
  inj_packet_t              push_pkt;
  inj_packet_t              head_pkt;
  logic                     fifo_full;
  logic                     fifo_empty;

  assign in_run   = (state_reg == RUN);
  assign stop_hit = (current_cycle == stop_cycle);
  // The stop cycle itself never injects
  assign inject   = in_run && !stop_hit &&
                    (lfsr_reg[RATE_WIDTH-1:0] < injection_rate);
  assign pop      = !fifo_empty && out_ready;
  assign push_ok  = inject && (!fifo_full || pop);
  assign blocked  = inject && !push_ok;

  assign dest_raw = lfsr_reg[15 -: NODE_ID_WIDTH];
  assign dest_sel = (dest_raw == SRC_NODE) ? ALT_NODE : dest_raw;

`ifdef TRAFFIC_INJECTOR_STALL_EN
  // Freezing the LFSR makes the blocked injection reappear identically next cycle
  assign lfsr_adv = in_run && !blocked;
`else
  assign lfsr_adv = in_run;
`endif

  // Assemble the packet offered to the buffer this cycle
  always_comb begin
    push_pkt           = '0;
    push_pkt.dest      = dest_sel;
    push_pkt.timestamp = current_cycle;
    push_pkt.id        = id_reg;
  end

  // Phase sequencing; DONE is only left through reset
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (start)      state_next = RUN;
      RUN:     if (stop_hit)   state_next = DRAIN;
      DRAIN:   if (fifo_empty) state_next = DONE;
      default: state_next = state_reg;
    endcase
  end

  // Phase, LFSR, packet id and accepted-injection counter
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_reg   <= IDLE;
      lfsr_reg    <= LFSR_SEED;
      id_reg      <= '0;
      inj_cnt_reg <= '0;
    end else begin
      state_reg <= state_next;
      if (lfsr_adv) lfsr_reg <= lfsr_next(lfsr_reg);
      if (push_ok) begin
        id_reg <= id_reg + 8'd1;
        if (inj_cnt_reg != 16'hFFFF) inj_cnt_reg <= inj_cnt_reg + 16'd1;
      end
    end
  end

`ifdef TRAFFIC_INJECTOR_STALL_EN
  assign dropped_count = '0;
`else
  logic [15:0] drop_cnt_reg;

  // Count injections lost to a full buffer, saturating
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      drop_cnt_reg <= '0;
    end else if (blocked && drop_cnt_reg != 16'hFFFF) begin
      drop_cnt_reg <= drop_cnt_reg + 16'd1;
    end
  end

  assign dropped_count = drop_cnt_reg;
`endif

  sync_fifo #(
    .DEPTH (FIFO_DEPTH),
    .T     (inj_packet_t)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (inject),
    .pop     (pop),
    .wr_data (push_pkt),
    .rd_data (head_pkt),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  // Head fields read as zero while nothing is buffered
  assign out_valid      = !fifo_empty;
  assign out_dest       = fifo_empty ? '0 : head_pkt.dest;
  assign out_timestamp  = fifo_empty ? '0 : head_pkt.timestamp;
  assign out_packet_id  = fifo_empty ? '0 : head_pkt.id;
  assign state          = state_reg;
  assign injected_count = inj_cnt_reg;

endmodule
